pipeline_control: RTL and testbench

Central stall/flush sequencer for the 16-bit five-stage core. It gates the PC and IF/ID pipeline register and injects ID/EX bubbles to cover three hazards: load-use, taken branches resolved in EX, and fixed-latency multi-cycle MUL/DIV. It sits beside the decode stage, takes operand indices from ID and hazard status from EX, and drives the write enables of the front-end pipeline registers. It also keeps a saturating stall-cycle statistic.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/sat_counter16.sv | 34 +++
 rtl/pipeline_control.sv | 107 ++++++++++
 tb/tb_pipeline_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage core: opcodes, register
// index width and the front-end sequencer state type.
package cpu_pkg;

  localparam int REG_BITS = 4;

  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1100;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } pc_state_t;

  // True for opcodes that occupy EX for several cycles.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at all-ones; clear has priority over increment.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 16'h0000;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Front-end stall/flush sequencer: handles load-use stalls, taken-branch
// flushes and fixed-latency MUL/DIV occupancy of EX, and counts stall cycles.
module pipeline_control
  import cpu_pkg::*;
#(
  parameter int REG_BITS      = cpu_pkg::REG_BITS,
  parameter int MULDIV_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [3:0]          id_opcode,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_branch_taken,
  input  logic                stat_clear,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                muldiv_start,
  output logic                muldiv_busy,
  output logic [15:0]         stall_cycles
);

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  pc_state_t  state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       load_use;
  logic       rs1_hit;
  logic       rs2_hit;

  // Register 0 is hardwired, so a zero destination never creates a hazard.
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && id_valid && (ex_rd != '0) && (rs1_hit || rs2_hit);

  // Next state and same-cycle control outputs; outputs stay at their
  // reset values while rst_n is low.
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_valid && is_muldiv(id_opcode)) begin
            // The MUL/DIV itself advances into EX this cycle.
            muldiv_start = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            md_cnt_d     = MD_LOAD;
            state_d      = MD_WAIT;
          end
        end
        MD_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          muldiv_busy = 1'b1;
          md_cnt_d    = md_cnt_q - 4'd1;
          if (md_cnt_q <= 4'd1) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state and MUL/DIV occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clear),
    .inc_i   (~pc_write),
    .count_o (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench: each driven cycle pushes its hand-computed expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_pipeline_control;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [3:0]  id_opcode, id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_branch_taken, stat_clear;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        muldiv_start, muldiv_busy;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_control #(.REG_BITS(4), .MULDIV_CYCLES(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .stat_clear      (stat_clear),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .muldiv_start    (muldiv_start),
    .muldiv_busy     (muldiv_busy),
    .stall_cycles    (stall_cycles)
  );

  // Control bits ordered {pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_start, muldiv_busy}
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] BR    = 6'b111100;
  localparam logic [5:0] ISSUE = 6'b000010;
  localparam logic [5:0] WAITC = 6'b000101;

  typedef struct {
    string       name;
    logic [5:0]  ctl;
    logic [15:0] sc;
  } vec_t;

  vec_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t cur;
  logic [5:0] act_ctl;

  // Monitor: compare one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      act_ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_start, muldiv_busy};
      n_vec++;
      if (act_ctl !== cur.ctl || stall_cycles !== cur.sc) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b stall=%h, want ctl=%b stall=%h",
                 cur.name, act_ctl, stall_cycles, cur.ctl, cur.sc);
      end else begin
        $display("ok   %s: ctl=%b stall=%h", cur.name, act_ctl, stall_cycles);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input logic [5:0] ctl, input logic [15:0] sc);
    vec_t v;
    v.name = name;
    v.ctl  = ctl;
    v.sc   = sc;
    q.push_back(v);
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [3:0] r1,
                        input logic [3:0] r2, input logic u1, input logic u2,
                        input logic mr, input logic [3:0] rd, input logic br);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    stat_clear = 1'b0;
    // Hazards everywhere on the inputs, but reset forces the outputs.
    set_in(1, OP_MUL, 3, 3, 1, 1, 1, 3, 1);
    cyc(); expect_v("reset", NORM, 16'd0);
    cyc(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("idle", NORM, 16'd0);

    // Load-use on rs2, then one cycle later the load has left EX.
    cyc(); set_in(1, 4'h0, 1, 3, 0, 1, 1, 3, 0); expect_v("lu_rs2", STALL, 16'd0);
    cyc(); set_in(1, 4'h0, 1, 3, 0, 1, 0, 3, 0); expect_v("lu_rs2_after", NORM, 16'd1);
    // Index zero and unused source never stall.
    cyc(); set_in(1, 4'h0, 0, 7, 1, 0, 1, 0, 0); expect_v("rd_zero", NORM, 16'd1);
    cyc(); set_in(1, 4'h0, 5, 7, 0, 0, 1, 5, 0); expect_v("rs1_unused", NORM, 16'd1);
    cyc(); set_in(1, 4'h0, 5, 7, 1, 0, 1, 5, 0); expect_v("lu_rs1", STALL, 16'd1);
    cyc(); set_in(1, 4'h0, 5, 7, 1, 0, 0, 5, 0); expect_v("lu_rs1_after", NORM, 16'd2);

    // Taken branch beats load-use and MUL issue.
    cyc(); set_in(1, OP_MUL, 3, 0, 1, 0, 1, 3, 1); expect_v("br_prio", BR, 16'd2);

    // Single MUL: issue at N, wait N+1..N+7, free at N+8.
    cyc(); set_in(1, OP_MUL, 3, 0, 1, 0, 0, 3, 0); expect_v("mul_issue", ISSUE, 16'd2);
    for (int i = 1; i <= 7; i++) begin
      cyc(); set_in(0, 0, 3, 3, 1, 1, 1, 3, 1); expect_v("mul_wait", WAITC, 16'(2 + i));
    end
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("mul_done", NORM, 16'd10);

    // Back-to-back MUL: second issues right after the first wait.
    cyc(); set_in(1, OP_MUL, 0, 0, 0, 0, 0, 0, 0); expect_v("b2b_issue1", ISSUE, 16'd10);
    for (int i = 1; i <= 7; i++) begin
      cyc(); expect_v("b2b_wait1", WAITC, 16'(10 + i));
    end
    cyc(); expect_v("b2b_issue2", ISSUE, 16'd18);
    for (int i = 1; i <= 7; i++) begin
      cyc(); expect_v("b2b_wait2", WAITC, 16'(18 + i));
    end
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("b2b_done", NORM, 16'd26);

    // Reset at N+3 of a DIV wait.
    cyc(); set_in(1, OP_DIV, 0, 0, 0, 0, 0, 0, 0); expect_v("div_issue", ISSUE, 16'd26);
    cyc(); expect_v("div_wait1", WAITC, 16'd27);
    cyc(); expect_v("div_wait2", WAITC, 16'd28);
    cyc(); rst_n = 1'b0; expect_v("div_rst", NORM, 16'd0);
    cyc(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("post_rst", NORM, 16'd0);

    // Saturation: continuous MUL stream keeps pc_write low for 70000+ cycles.
    cyc(); set_in(1, OP_MUL, 0, 0, 0, 0, 0, 0, 0); expect_v("sat_issue", ISSUE, 16'd0);
    repeat (70000) cyc();
    cyc(); expect_v("sat_hold", WAITC, 16'hFFFF);
    cyc(); stat_clear = 1'b1; expect_v("clr_edge", WAITC, 16'hFFFF);
    cyc(); stat_clear = 1'b0; expect_v("clr_done", WAITC, 16'd0);
    cyc(); expect_v("clr_count", WAITC, 16'd1);

    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
